// File: rtl/serial_port_ctrl_pkg.sv
// Shared types and constants for the serial
// port-demultiplexer control unit.
package serial_port_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PORT = 3'd1,
    S_NUM  = 3'd2,
    S_LOAD = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int PORT_BITS = 2;
  localparam int NUM_BITS  = 4;

endpackage

// File: rtl/serial_port_ctrl_start_arm.sv
// Start-bit qualifier: counts idle-level bits
// and flags a start only once armed.
module serial_port_ctrl_start_arm #(
  parameter int   ARM_BITS    = 2,
  parameter logic START_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_ser,
  output logic o_start
);

  logic [3:0] r_arm;
  logic       w_armed;
  logic       w_is_start;

  assign w_armed    = (r_arm >= 4'(ARM_BITS));
  assign w_is_start = (i_ser == START_LEVEL);
  assign o_start    = i_en & w_armed & w_is_start;

  // Saturating arm counter; an early start level disarms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arm <= 4'd0;
    end else if (i_clr) begin
      r_arm <= 4'd0;
    end else if (i_en) begin
      if (w_is_start) begin
        if (!w_armed) r_arm <= 4'd0;
      end else if (!w_armed) begin
        r_arm <= r_arm + 4'd1;
      end
    end
  end

endmodule

// File: rtl/serial_port_ctrl.sv
// Frame sequencer driving the serial
// port-demultiplexer datapath controls.
module serial_port_ctrl
  import serial_port_ctrl_pkg::*;
#(
  parameter int   ARM_BITS    = 2,
  parameter logic START_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clkEn,
  input  logic serIn,
  input  logic co1,
  input  logic co2,
  input  logic coD,
  output logic shEn,
  output logic cnt1,
  output logic shEnD,
  output logic cnt2,
  output logic ldCntD,
  output logic cntD,
  output logic serCntValid,
  output logic Done,
  output logic busy
);

  state_t r_state;
  state_t w_next;
  logic   w_start;

  serial_port_ctrl_start_arm #(
    .ARM_BITS   (ARM_BITS),
    .START_LEVEL(START_LEVEL)
  ) u_arm (
    .clk    (clk),
    .rst    (rst),
    .i_en   (clkEn & (r_state == S_IDLE)),
    .i_clr  (clkEn & (r_state == S_DONE)),
    .i_ser  (serIn),
    .o_start(w_start)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state; carry-outs only matter in their own state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start)       w_next = S_PORT;
      S_PORT: if (clkEn & co1)   w_next = S_NUM;
      S_NUM:  if (clkEn & co2)   w_next = S_LOAD;
      S_LOAD: if (clkEn)         w_next = S_DATA;
      S_DATA: if (clkEn & coD)   w_next = S_DONE;
      S_DONE: if (clkEn)         w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Output decode, strobes qualified by the bit enable.
  always_comb begin
    shEn        = clkEn & (r_state == S_PORT);
    cnt1        = clkEn & (r_state == S_PORT);
    shEnD       = clkEn & (r_state == S_NUM);
    cnt2        = clkEn & (r_state == S_NUM);
    ldCntD      = clkEn & (r_state == S_LOAD);
    cntD        = clkEn & (r_state == S_DATA);
    serCntValid = clkEn & (r_state == S_DATA);
    Done        = clkEn & (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Directed vector bench for serial_port_ctrl
// (ARM_BITS=2, START_LEVEL=0).
module tb_serial_port_ctrl;
  import serial_port_ctrl_pkg::*;

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_PORT = 8'b1100_0000;
  localparam logic [7:0] O_NUM  = 8'b0011_0000;
  localparam logic [7:0] O_LOAD = 8'b0000_1000;
  localparam logic [7:0] O_DATA = 8'b0000_0110;
  localparam logic [7:0] O_DONE = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clkEn = 1'b0;
  logic serIn = 1'b1;
  logic co1 = 1'b0;
  logic co2 = 1'b0;
  logic coD = 1'b0;
  logic shEn, cnt1, shEnD, cnt2;
  logic ldCntD, cntD, serCntValid;
  logic Done, busy;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       ce;
    logic       si;
    logic       c1;
    logic       c2;
    logic       cd;
    logic [7:0] eo;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  serial_port_ctrl #(
    .ARM_BITS   (2),
    .START_LEVEL(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkEn      (clkEn),
    .serIn      (serIn),
    .co1        (co1),
    .co2        (co2),
    .coD        (coD),
    .shEn       (shEn),
    .cnt1       (cnt1),
    .shEnD      (shEnD),
    .cnt2       (cnt2),
    .ldCntD     (ldCntD),
    .cntD       (cntD),
    .serCntValid(serCntValid),
    .Done       (Done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {shEn, cnt1, shEnD, cnt2,
            ldCntD, cntD, serCntValid, Done};
  endfunction

  task automatic check(input string nm,
                       input logic [7:0] eo,
                       input logic eb);
    n_chk++;
    if (outs() !== eo) begin
      n_fail++;
      $display("FAIL %s outs got %b want %b t=%0t",
               nm, outs(), eo, $time);
    end
    n_chk++;
    if (busy !== eb) begin
      n_fail++;
      $display("FAIL %s busy got %b want %b t=%0t",
               nm, busy, eb, $time);
    end
  endtask

  task automatic apply(input string nm,
                       input logic ce,
                       input logic si,
                       input logic c1,
                       input logic c2,
                       input logic cd,
                       input logic [7:0] eo,
                       input logic eb);
    @(negedge clk);
    clkEn = ce;
    serIn = si;
    co1   = c1;
    co2   = c2;
    coD   = cd;
    #1;
    check(nm, eo, eb);
  endtask

  task automatic add(input logic ce, input logic si,
                     input logic c1, input logic c2,
                     input logic cd, input logic [7:0] eo,
                     input logic eb);
    tbl.push_back(vec_t'{ce, si, c1, c2, cd, eo, eb});
  endtask

  // Frame body from the first port bit; abort>0 stops
  // after that many data bits without asserting coD.
  task automatic body(input string nm, input int n,
                      input int abort);
    logic r;
    for (int i = 0; i < PORT_BITS; i++) begin
      r = 1'($urandom_range(0, 1));
      apply({nm, "_port"}, 1, r,
            (i == PORT_BITS - 1), 0, 0, O_PORT, 1);
    end
    for (int i = 0; i < NUM_BITS; i++) begin
      r = 1'($urandom_range(0, 1));
      apply({nm, "_num"}, 1, r,
            0, (i == NUM_BITS - 1), 0, O_NUM, 1);
    end
    apply({nm, "_load"}, 1, 0, 0, 0, 0, O_LOAD, 1);
    for (int i = 0; i < n; i++) begin
      if (abort > 0 && i == abort) return;
      r = 1'($urandom_range(0, 1));
      apply({nm, "_data"}, 1, r, 0, 0,
            (i == n - 1), O_DATA, 1);
    end
    apply({nm, "_done"}, 1, 0, 0, 0, 0, O_DONE, 1);
  endtask

  initial begin
    // Main frame, N=5; co* outside their states are noise.
    add(1, 1, 1, 1, 1, O_IDLE, 0);
    add(1, 1, 0, 0, 0, O_IDLE, 0);
    add(1, 0, 0, 0, 0, O_IDLE, 0);
    add(1, 1, 0, 1, 1, O_PORT, 1);
    add(1, 0, 1, 0, 0, O_PORT, 1);
    add(1, 1, 1, 0, 1, O_NUM,  1);
    add(1, 0, 0, 0, 0, O_NUM,  1);
    add(1, 1, 0, 0, 0, O_NUM,  1);
    add(1, 0, 0, 1, 0, O_NUM,  1);
    add(1, 0, 1, 1, 1, O_LOAD, 1);
    add(1, 1, 1, 1, 0, O_DATA, 1);
    add(1, 0, 0, 0, 0, O_DATA, 1);
    add(1, 1, 0, 0, 0, O_DATA, 1);
    add(1, 0, 0, 0, 0, O_DATA, 1);
    add(1, 1, 0, 0, 1, O_DATA, 1);
    add(1, 1, 1, 1, 1, O_DONE, 1);
    add(1, 0, 0, 0, 0, O_IDLE, 0);
    add(1, 0, 0, 0, 0, O_IDLE, 0);

    clkEn = 1'b1;
    #2;
    check("reset", O_IDLE, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      apply($sformatf("tbl%0d", i), tbl[i].ce,
            tbl[i].si, tbl[i].c1, tbl[i].c2,
            tbl[i].cd, tbl[i].eo, tbl[i].eb);

    // Same frame with clkEn pulsing 1-in-4.
    foreach (tbl[i]) begin
      logic nb;
      nb = (i + 1 < tbl.size()) ? tbl[i + 1].eb : 1'b0;
      apply($sformatf("slow%0d", i), tbl[i].ce,
            tbl[i].si, tbl[i].c1, tbl[i].c2,
            tbl[i].cd, tbl[i].eo, tbl[i].eb);
      for (int g = 0; g < 3; g++)
        apply($sformatf("gap%0d", i), 0,
              1'($urandom_range(0, 1)), 1, 1, 1,
              O_IDLE, nb);
    end

    // A single idle bit must not arm the detector.
    apply("arm1_a", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("arm1_b", 1, 0, 0, 0, 0, O_IDLE, 0);
    apply("arm1_c", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("arm1_d", 1, 0, 0, 0, 0, O_IDLE, 0);
    apply("arm1_e", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("arm1_f", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("arm1_g", 1, 0, 0, 0, 0, O_IDLE, 0);
    body("cod1", 1, 0);
    apply("cod1_end", 1, 0, 0, 0, 0, O_IDLE, 0);
    apply("cod1_rej", 1, 0, 0, 0, 0, O_IDLE, 0);

    // Reset asserted in DATA aborts at once.
    apply("rs_a", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("rs_b", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("rs_c", 1, 0, 0, 0, 0, O_IDLE, 0);
    body("rs", 6, 2);
    @(negedge clk);
    clkEn = 1'b1;
    serIn = 1'b1;
    coD   = 1'b0;
    #1;
    check("rs_pre", O_DATA, 1);
    rst = 1'b0;
    #1;
    check("rs_async", O_IDLE, 0);
    @(negedge clk);
    rst = 1'b1;
    apply("rs_post0", 1, 0, 0, 0, 0, O_IDLE, 0);
    apply("rs_post1", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("rs_post2", 1, 1, 0, 0, 0, O_IDLE, 0);
    apply("rs_post3", 1, 0, 0, 0, 0, O_IDLE, 0);
    body("rs2", 3, 0);
    apply("rs2_end", 1, 1, 0, 0, 0, O_IDLE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
